sram16_ctrl: RTL and testbench

//  Downstream memory stage for the RISC5 core. Turns each CPU access (instruction fetch,

---
 rtl/sram16_if.sv | 34 +++
 rtl/sram16_ctrl.sv | 91 +++++++++
 tb/tb_sram16_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram16_if.sv
// CPU request/response and external 16-bit SRAM pins of sram16_ctrl.
// Handshake: the CPU holds adr/rd/wr/ben/outbus stable while stallX=1; the single
// cycle with stallX=0 completes the access and inbus/codebus are valid in it.
interface sram16_if #(parameter int AW = 19);
    logic [23:0]   adr;
    logic          rd;
    logic          wr;
    logic          ben;
    logic [31:0]   outbus;
    logic [31:0]   inbus;
    logic [31:0]   codebus;
    logic          stallX;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_i;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_ub_n;
    logic          sram_lb_n;

    modport slave (
        input  adr, rd, wr, ben, outbus, sram_dq_i,
        output inbus, codebus, stallX, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output adr, rd, wr, ben, outbus, sram_dq_i,
        input  inbus, codebus, stallX, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram16_ctrl.sv
// Splits each 32-bit CPU access into one or two half-word cycles on a 16-bit async SRAM
// and stalls the core until the word is assembled.
module sram16_ctrl #(
    parameter int AW = 19,
    parameter int WS = 1
) (
    input  logic       clk,
    input  logic       rst,
    sram16_if.slave    bus,
    output logic [1:0] state_dbg
);
    typedef enum logic [1:0] {S_LO = 2'd0, S_HI = 2'd1, S_DONE = 2'd2} state_t;
    localparam logic [3:0] WS_LAST = 4'(WS);

    state_t      state;
    state_t      state_next;
    logic [3:0]  ws_cnt;
    logic [31:0] rdata;
    logic        is_wr;
    logic        is_byte;
    logic        hi_only;
    logic        half;
    logic        last;
    logic        active;
    logic        rd_cap;
    logic        adr_unused;

    // Byte addresses above the SRAM size simply alias.
    assign adr_unused = |(bus.adr >> (AW + 1));

    // S_LO is the entry state; a high-lane byte access runs its only half from it.
    always_comb begin
        is_wr   = bus.wr;
        is_byte = bus.ben & (bus.rd | bus.wr);
        hi_only = is_byte & bus.adr[1];
        half    = (state == S_HI) || ((state == S_LO) && hi_only);
        last    = (ws_cnt == WS_LAST);
        active  = !rst && (state != S_DONE);
        rd_cap  = active && !is_wr && last;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_LO:    if (last) state_next = is_byte ? S_DONE : S_HI;
            S_HI:    if (last) state_next = S_DONE;
            default: state_next = S_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_LO;
            ws_cnt <= 4'd0;
        end else begin
            state  <= state_next;
            ws_cnt <= (state_next != state) ? 4'd0 : ws_cnt + 4'd1;
        end
    end

    // Byte loads zero the unused half so the CPU lane select on adr[1:0] works.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (rd_cap) begin
            if (half) begin
                rdata[31:16] <= bus.sram_dq_i;
                if (is_byte) rdata[15:0] <= 16'd0;
            end else begin
                rdata[15:0] <= bus.sram_dq_i;
                if (is_byte) rdata[31:16] <= 16'd0;
            end
        end
    end

    // Strobes are gated by rst directly so a reset aborts a write without a clock edge.
    always_comb begin
        bus.stallX     = rst || (state != S_DONE);
        bus.sram_addr  = {bus.adr[AW:2], half};
        bus.sram_ce_n  = !active;
        bus.sram_oe_n  = !(active && !is_wr);
        bus.sram_we_n  = !(active && is_wr);
        bus.sram_dq_oe = active && is_wr;
        bus.sram_dq_o  = half ? bus.outbus[31:16] : bus.outbus[15:0];
        bus.sram_lb_n  = !active || (is_wr && is_byte && bus.adr[0]);
        bus.sram_ub_n  = !active || (is_wr && is_byte && !bus.adr[0]);
        bus.inbus      = rdata;
        bus.codebus    = rdata;
        state_dbg      = ((state == S_LO) && hi_only) ? S_HI : state;
    end
endmodule

// File: tb/tb_sram16_ctrl.sv
// Bench for sram16_ctrl: WS=0 and WS=2 instances, each with its own behavioural SRAM,
// table-driven access vectors plus hand sequences for timing, lanes and reset abort.
module tb_sram16_ctrl;
    localparam int AW = 19;
    localparam int NV = 13;
    localparam int LOGN = 48;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram16_if #(.AW(AW)) bus0 ();
    sram16_if #(.AW(AW)) bus2 ();
    logic [1:0] st0;
    logic [1:0] st2;

    sram16_ctrl #(.AW(AW), .WS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
    sram16_ctrl #(.AW(AW), .WS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .state_dbg(st2));

    // ---------------- SRAM models ----------------
    logic [15:0] mem0 [logic [AW-1:0]];
    logic [15:0] mem2 [logic [AW-1:0]];

    function automatic logic [15:0] peek(input int sel, input logic [AW-1:0] a);
        if (sel == 0) return mem0.exists(a) ? mem0[a] : 16'h0000;
        return mem2.exists(a) ? mem2[a] : 16'h0000;
    endfunction

    function automatic void poke(input int sel, input logic [AW-1:0] a, input logic [15:0] d,
                                 input logic ub_n, input logic lb_n);
        logic [15:0] old;
        logic [15:0] nw;
        old = peek(sel, a);
        nw  = {ub_n ? old[15:8] : d[15:8], lb_n ? old[7:0] : d[7:0]};
        if (sel == 0) mem0[a] = nw;
        else mem2[a] = nw;
    endfunction

    always @(clk or bus0.sram_addr or bus0.sram_oe_n)
        bus0.sram_dq_i = bus0.sram_oe_n ? 16'h0000 : peek(0, bus0.sram_addr);
    always @(clk or bus2.sram_addr or bus2.sram_oe_n)
        bus2.sram_dq_i = bus2.sram_oe_n ? 16'h0000 : peek(2, bus2.sram_addr);

    always @(negedge clk) begin
        if (!bus0.sram_ce_n && !bus0.sram_we_n)
            poke(0, bus0.sram_addr, bus0.sram_dq_o, bus0.sram_ub_n, bus0.sram_lb_n);
        if (!bus2.sram_ce_n && !bus2.sram_we_n)
            poke(2, bus2.sram_addr, bus2.sram_dq_o, bus2.sram_ub_n, bus2.sram_lb_n);
    end

    // ---------------- scoreboard and logs ----------------
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    int lat;
    logic [31:0] data_done;
    logic [31:0] code_done;
    logic [AW-1:0] addr_log [LOGN];
    logic          stall_log [LOGN];
    logic          we_log [LOGN];
    logic          lb_log [LOGN];
    logic          ub_log [LOGN];
    logic          oe_log [LOGN];
    logic [15:0]   dq_log [LOGN];

    typedef struct {
        logic        rd;
        logic        wr;
        logic        ben;
        logic [23:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_we;
    } vec_t;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic get_stall(input int sel);
        return (sel == 0) ? bus0.stallX : bus2.stallX;
    endfunction

    task automatic drive(input int sel, input logic rd_v, input logic wr_v, input logic ben_v,
                         input logic [23:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.rd = rd_v; bus0.wr = wr_v; bus0.ben = ben_v; bus0.adr = a; bus0.outbus = wd;
        end else begin
            bus2.rd = rd_v; bus2.wr = wr_v; bus2.ben = ben_v; bus2.adr = a; bus2.outbus = wd;
        end
    endtask

    task automatic sample_now(input int sel, input int idx);
        if (sel == 0) begin
            addr_log[idx] = bus0.sram_addr; stall_log[idx] = bus0.stallX;
            we_log[idx] = bus0.sram_we_n; lb_log[idx] = bus0.sram_lb_n;
            ub_log[idx] = bus0.sram_ub_n; oe_log[idx] = bus0.sram_dq_oe;
            dq_log[idx] = bus0.sram_dq_o;
        end else begin
            addr_log[idx] = bus2.sram_addr; stall_log[idx] = bus2.stallX;
            we_log[idx] = bus2.sram_we_n; lb_log[idx] = bus2.sram_lb_n;
            ub_log[idx] = bus2.sram_ub_n; oe_log[idx] = bus2.sram_dq_oe;
            dq_log[idx] = bus2.sram_dq_o;
        end
    endtask

    function automatic int count_we();
        int n = 0;
        for (int k = 1; k <= lat; k++) if (we_log[k] == 1'b0) n++;
        return n;
    endfunction

    // Samples the current cycle as cycle 1, then one sample per falling edge until stallX=0.
    task automatic wait_done(input int sel, input bit is_read, input string name);
        bit done;
        logic [31:0] exp;
        done = 1'b0;
        lat = 0;
        for (int g = 0; g < 40 && !done; g++) begin
            if (g > 0) @(negedge clk);
            lat++;
            sample_now(sel, lat);
            if (stall_log[lat] == 1'b0) done = 1'b1;
        end
        if (!done) begin
            fail_now({name, "_timeout"});
        end else begin
            data_done = (sel == 0) ? bus0.inbus : bus2.inbus;
            code_done = (sel == 0) ? bus0.codebus : bus2.codebus;
            if (is_read) begin
                if (exp_q.size() == 0) fail_now({name, "_queue"});
                else begin
                    exp = exp_q.pop_front();
                    check(name, data_done, exp);
                end
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    endtask

    task automatic sync(input int sel, input string name);
        int g = 0;
        while (get_stall(sel) && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (get_stall(sel)) fail_now({name, "_sync"});
    endtask

    task automatic access(input int sel, input logic rd_v, input logic wr_v, input logic ben_v,
                          input logic [23:0] a, input logic [31:0] wd, input logic [31:0] exp_d,
                          input string name);
        bit is_read;
        is_read = !wr_v;
        sync(sel, name);
        drive(sel, rd_v, wr_v, ben_v, a, wd);
        if (is_read) exp_q.push_back(exp_d);
        @(negedge clk);
        wait_done(sel, is_read, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] hb;
        logic [6:0] sb;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        mem0[19'h00080] = 16'h5678;
        mem0[19'h00081] = 16'h1234;
        mem2[19'h00100] = 16'h1111;
        mem2[19'h00101] = 16'h2222;

        //          rd    wr    ben   adr         wdata         exp_data     lat we
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 32'hDEADBEEF, 32'h0,        7, 6};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 32'h0,        32'hDEADBEEF, 7, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 24'h000202, 32'h00CD0000, 32'h0,        4, 3};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 24'h000200, 32'h0,        32'h22CD1111, 7, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 24'h000001, 32'h00005A00, 32'h0,        4, 3};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 24'h000001, 32'h0,        32'h00005AEF, 4, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 24'h000003, 32'h0,        32'hDEAD0000, 4, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 24'h000003, 32'h77000000, 32'h0,        4, 3};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 32'h0,        32'h77AD5AEF, 7, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'hF00200, 32'h0,        32'h22CD1111, 7, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 24'h0FFFFC, 32'h0BADF00D, 32'h0,        7, 6};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 24'h0FFFFC, 32'h0,        32'h0BADF00D, 7, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 24'h0FFFFE, 32'h0,        32'h0BAD0000, 4, 0};

        // reset state
        #12;
        check("rst_stall", bus0.stallX, 1'b1);
        check("rst_strobes", {bus0.sram_ce_n, bus0.sram_oe_n, bus0.sram_we_n,
                              bus0.sram_ub_n, bus0.sram_lb_n, bus0.sram_dq_oe}, 6'b111110);
        check("rst_inbus", bus2.inbus, 32'h0);
        check("rst_state", st2, 2'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // WS=0 fetch: stallX 1,1,0 and codebus assembled from two halves
        access(0, 1'b0, 1'b0, 1'b0, 24'h000100, 32'h0, 32'h12345678, "fetch_ws0");
        check("fetch_ws0_lat", lat, 3);
        check("fetch_ws0_stall", {stall_log[1], stall_log[2], stall_log[3]}, 3'b110);
        check("fetch_ws0_codebus", code_done, 32'h12345678);
        check("fetch_ws0_addr_lo", addr_log[1], 19'h00080);
        check("fetch_ws0_addr_hi", addr_log[2], 19'h00081);

        // WS=0 high-lane byte load: single S_HI half
        mem0[19'h00081] = 16'hAB00;
        access(0, 1'b1, 1'b0, 1'b1, 24'h000103, 32'h0, 32'hAB000000, "bload_hi");
        check("bload_hi_lat", lat, 2);
        check("bload_hi_addr", addr_log[1], 19'h00081);

        // WS=0 byte store to lane 2
        access(0, 1'b0, 1'b1, 1'b1, 24'h000202, 32'h00CD0000, 32'h0, "bstore");
        check("bstore_lat", lat, 2);
        check("bstore_addr", addr_log[1], 19'h00101);
        check("bstore_lanes", {lb_log[1], ub_log[1], oe_log[1]}, 3'b011);
        check("bstore_dq", dq_log[1], 16'h00CD);
        check("bstore_we_cycles", count_we(), 1);
        check("bstore_mem", peek(0, 19'h00101), 16'h00CD);

        // WS=2 table
        for (int i = 0; i < NV; i++) begin
            access(2, vecs[i].rd, vecs[i].wr, vecs[i].ben, vecs[i].adr, vecs[i].wdata,
                   vecs[i].exp_data, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_we", i), count_we(), vecs[i].exp_we);
        end

        // WS=2 word load: half bit flips after 3 clocks, stall high 6 then low
        access(2, 1'b1, 1'b0, 1'b0, 24'h000200, 32'h0, 32'h22CD1111, "ws2_word");
        for (int k = 1; k <= 6; k++) hb[k-1] = addr_log[k][0];
        for (int k = 1; k <= 7; k++) sb[k-1] = stall_log[k];
        check("ws2_word_half", hb, 6'b111000);
        check("ws2_word_stall", sb, 7'b0111111);

        // reset during the high half of a word store
        sync(2, "rst_mid");
        drive(2, 1'b0, 1'b1, 1'b0, 24'h000400, 32'h11112222);
        repeat (4) @(negedge clk);
        check("rst_mid_in_hi", {st2, bus2.sram_we_n}, 3'b010);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_strobes", {bus2.sram_ce_n, bus2.sram_oe_n, bus2.sram_we_n,
                                  bus2.sram_dq_oe, bus2.stallX}, 5'b11101);
        check("rst_mid_state", st2, 2'd0);
        check("rst_mid_inbus", bus2.inbus, 32'h0);
        drive(2, 1'b1, 1'b0, 1'b0, 24'h000000, 32'h0);
        exp_q.push_back(32'h77AD5AEF);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_rel_state", st2, 2'd0);
        check("rst_rel_half", bus2.sram_addr[0], 1'b0);
        wait_done(2, 1'b1, "rst_reload");
        check("rst_reload_lat", lat, 7);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
